// File: rtl/riscv_lsu_pkg.sv
// Shared definitions for the memory-stage load/store unit: funct3 codes,
// FSM state encoding, byte-enable base masks and small alignment helpers.
package riscv_lsu_pkg;

  // funct3 width/sign codes (RV64)
  localparam logic [2:0] F3_B   = 3'b000;
  localparam logic [2:0] F3_H   = 3'b001;
  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_D   = 3'b011;
  localparam logic [2:0] F3_BU  = 3'b100;
  localparam logic [2:0] F3_HU  = 3'b101;
  localparam logic [2:0] F3_WU  = 3'b110;
  localparam logic [2:0] F3_ILL = 3'b111;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;
  localparam logic [1:0] ST_ERR  = 2'd3;

  // Byte-enable masks before lane shifting
  localparam logic [7:0] BE_B = 8'h01;
  localparam logic [7:0] BE_H = 8'h03;
  localparam logic [7:0] BE_W = 8'h0F;
  localparam logic [7:0] BE_D = 8'hFF;

  // Base byte-enable mask for an access size code (funct3[1:0])
  function automatic logic [7:0] be_base(input logic [1:0] sz);
    case (sz)
      2'd0:    be_base = BE_B;
      2'd1:    be_base = BE_H;
      2'd2:    be_base = BE_W;
      default: be_base = BE_D;
    endcase
  endfunction

  // Clear the low address bits that fall inside the access width
  function automatic logic [2:0] align_lo(input logic [1:0] sz, input logic [2:0] a);
    case (sz)
      2'd0:    align_lo = a;
      2'd1:    align_lo = {a[2:1], 1'b0};
      2'd2:    align_lo = {a[2], 2'b00};
      default: align_lo = 3'b000;
    endcase
  endfunction

  // Address not naturally aligned for the access width
  function automatic logic misaligned(input logic [1:0] sz, input logic [2:0] a);
    misaligned = (align_lo(sz, a) != a);
  endfunction

  // Encodings that have no legal memory operation
  function automatic logic illegal_op(input logic [2:0] f3, input logic is_store);
    illegal_op = (f3 == F3_ILL) || (is_store && f3[2]);
  endfunction

endpackage

// File: rtl/riscv_lsu_align.sv
// Combinational lane logic: byte enables, store-data lane shift and
// load-data extraction with sign/zero extension. The low address bits are
// aligned down to the access width before use.
module riscv_lsu_align
  import riscv_lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [2:0]  i_addr_lo,
  input  logic [63:0] i_wdata,
  input  logic [63:0] i_rdata,
  output logic [7:0]  o_be,
  output logic [63:0] o_wdata,
  output logic [63:0] o_rdata
);

  logic [2:0]  w_lo;
  logic [5:0]  w_shamt;
  logic [63:0] w_wmask;
  logic [63:0] w_rshift;

  assign w_lo     = align_lo(i_funct3[1:0], i_addr_lo);
  assign w_shamt  = {w_lo, 3'b000};
  assign o_be     = be_base(i_funct3[1:0]) << w_lo;
  assign w_rshift = i_rdata >> w_shamt;

  // Keep only the bytes that are actually stored so disabled lanes stay zero
  always_comb begin
    case (i_funct3[1:0])
      2'd0:    w_wmask = 64'h0000_0000_0000_00FF;
      2'd1:    w_wmask = 64'h0000_0000_0000_FFFF;
      2'd2:    w_wmask = 64'h0000_0000_FFFF_FFFF;
      default: w_wmask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  end

  assign o_wdata = (i_wdata & w_wmask) << w_shamt;

  // Sign- or zero-extend the right-justified load value
  always_comb begin
    case (i_funct3)
      F3_B:    o_rdata = {{56{w_rshift[7]}},  w_rshift[7:0]};
      F3_H:    o_rdata = {{48{w_rshift[15]}}, w_rshift[15:0]};
      F3_W:    o_rdata = {{32{w_rshift[31]}}, w_rshift[31:0]};
      F3_BU:   o_rdata = {56'd0, w_rshift[7:0]};
      F3_HU:   o_rdata = {48'd0, w_rshift[15:0]};
      F3_WU:   o_rdata = {32'd0, w_rshift[31:0]};
      default: o_rdata = w_rshift;
    endcase
  end

endmodule

// File: rtl/riscv_lsu.sv
// Memory-stage load/store unit. Captures one load/store from the EX/MEM
// register, issues a single doubleword-aligned data-memory request and
// stalls the pipeline until the memory acks or the wait times out.
// Optional feature macro: RISCV_LSU_MISALIGN_TRAP_EN (misaligned accesses
// take the error path instead of being silently aligned down).
//
// Memory handshake: o_riscv_lsu_dmem_req stays high with addr/be/we/wdata
// stable from the cycle after the request until the cycle i_riscv_lsu_dmem_ack
// is sampled high; rdata is taken in that same ack cycle. An ack while no
// request is outstanding is ignored.
module riscv_lsu
  import riscv_lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        i_riscv_lsu_clk,
  input  logic        i_riscv_lsu_rst,
  input  logic        i_riscv_lsu_load,
  input  logic        i_riscv_lsu_store,
  input  logic [2:0]  i_riscv_lsu_funct3,
  input  logic [63:0] i_riscv_lsu_addr,
  input  logic [63:0] i_riscv_lsu_wdata,
  output logic        o_riscv_lsu_dmem_req,
  output logic        o_riscv_lsu_dmem_we,
  output logic [63:0] o_riscv_lsu_dmem_addr,
  output logic [7:0]  o_riscv_lsu_dmem_be,
  output logic [63:0] o_riscv_lsu_dmem_wdata,
  input  logic        i_riscv_lsu_dmem_ack,
  input  logic [63:0] i_riscv_lsu_dmem_rdata,
  output logic        o_riscv_lsu_stall,
  output logic        o_riscv_lsu_done,
  output logic [63:0] o_riscv_lsu_rdata,
  output logic        o_riscv_lsu_err
);

  localparam int              CNT_W      = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam bit              TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  logic [1:0]       r_state;
  logic [2:0]       r_funct3;
  logic [63:0]      r_addr;
  logic [63:0]      r_wdata;
  logic             r_we;
  logic [CNT_W-1:0] r_cnt;
  logic [63:0]      r_rdata;

  logic        w_req_any;
  logic        w_is_store;
  logic        w_misalign;
  logic        w_bad;
  logic        w_in_req;
  logic [7:0]  w_be;
  logic [63:0] w_wdata_sh;
  logic [63:0] w_load_data;

  assign w_req_any  = i_riscv_lsu_load | i_riscv_lsu_store;
  // Load wins if both are (illegally) asserted
  assign w_is_store = i_riscv_lsu_store & ~i_riscv_lsu_load;

`ifdef RISCV_LSU_MISALIGN_TRAP_EN
  assign w_misalign = misaligned(i_riscv_lsu_funct3[1:0], i_riscv_lsu_addr[2:0]);
`else
  assign w_misalign = 1'b0;
`endif

  assign w_bad    = illegal_op(i_riscv_lsu_funct3, w_is_store) | w_misalign;
  assign w_in_req = (r_state == ST_REQ);

  riscv_lsu_align u_align (
    .i_funct3  (r_funct3),
    .i_addr_lo (r_addr[2:0]),
    .i_wdata   (r_wdata),
    .i_rdata   (i_riscv_lsu_dmem_rdata),
    .o_be      (w_be),
    .o_wdata   (w_wdata_sh),
    .o_rdata   (w_load_data)
  );

  // Request FSM, captured request, timeout counter and registered load data
  always_ff @(posedge i_riscv_lsu_clk or posedge i_riscv_lsu_rst) begin
    if (i_riscv_lsu_rst) begin
      r_state  <= ST_IDLE;
      r_funct3 <= 3'd0;
      r_addr   <= 64'd0;
      r_wdata  <= 64'd0;
      r_we     <= 1'b0;
      r_cnt    <= '0;
      r_rdata  <= 64'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req_any) begin
            r_funct3 <= i_riscv_lsu_funct3;
            r_addr   <= i_riscv_lsu_addr;
            r_wdata  <= i_riscv_lsu_wdata;
            r_we     <= w_is_store;
            r_cnt    <= '0;
            r_state  <= w_bad ? ST_ERR : ST_REQ;
          end
        end
        ST_REQ: begin
          if (i_riscv_lsu_dmem_ack) begin
            r_rdata <= r_we ? 64'd0 : w_load_data;
            r_state <= ST_RESP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (TIMEOUT_EN && (r_cnt == CNT_LAST)) r_state <= ST_ERR;
          end
        end
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Memory-side outputs are only driven while a request is outstanding
  assign o_riscv_lsu_dmem_req   = w_in_req;
  assign o_riscv_lsu_dmem_we    = w_in_req & r_we;
  assign o_riscv_lsu_dmem_addr  = w_in_req ? {r_addr[63:3], 3'b000} : 64'd0;
  assign o_riscv_lsu_dmem_be    = w_in_req ? w_be : 8'd0;
  assign o_riscv_lsu_dmem_wdata = (w_in_req & r_we) ? w_wdata_sh : 64'd0;

  // Pipeline-side outputs
  assign o_riscv_lsu_stall = ((r_state == ST_IDLE) & w_req_any) | w_in_req;
  assign o_riscv_lsu_done  = (r_state == ST_RESP) | (r_state == ST_ERR);
  assign o_riscv_lsu_err   = (r_state == ST_ERR);
  assign o_riscv_lsu_rdata = (r_state == ST_RESP) ? r_rdata : 64'd0;

endmodule

// File: tb/tb_riscv_lsu.sv
// Bench for riscv_lsu: directed accesses from the examples, illegal and
// boundary cases, a randomized access loop, timeout and mid-access reset.
module tb_riscv_lsu;

  localparam int TO = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        i_load, i_store, i_ack;
  logic [2:0]  i_f3;
  logic [63:0] i_addr, i_wdata, i_rdata;
  logic        o_req, o_we, o_stall, o_done, o_err;
  logic [63:0] o_addr, o_wdata, o_rdata;
  logic [7:0]  o_be;

  riscv_lsu #(.TIMEOUT_CYCLES(TO)) dut (
    .i_riscv_lsu_clk        (clk),
    .i_riscv_lsu_rst        (rst),
    .i_riscv_lsu_load       (i_load),
    .i_riscv_lsu_store      (i_store),
    .i_riscv_lsu_funct3     (i_f3),
    .i_riscv_lsu_addr       (i_addr),
    .i_riscv_lsu_wdata      (i_wdata),
    .o_riscv_lsu_dmem_req   (o_req),
    .o_riscv_lsu_dmem_we    (o_we),
    .o_riscv_lsu_dmem_addr  (o_addr),
    .o_riscv_lsu_dmem_be    (o_be),
    .o_riscv_lsu_dmem_wdata (o_wdata),
    .i_riscv_lsu_dmem_ack   (i_ack),
    .i_riscv_lsu_dmem_rdata (i_rdata),
    .o_riscv_lsu_stall      (o_stall),
    .o_riscv_lsu_done       (o_done),
    .o_riscv_lsu_rdata      (o_rdata),
    .o_riscv_lsu_err        (o_err)
  );

  // scoreboard
  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Reference model: byte-by-byte view of one access
  function automatic void model(input bit ld, input bit st, input logic [2:0] f3,
                                input logic [63:0] addr, input logic [63:0] wdata,
                                input logic [63:0] mem, output bit err,
                                output logic [7:0] be, output logic [63:0] wd,
                                output logic [63:0] rd);
    int size, a, al;
    bit is_st;
    is_st = st && !ld;
    size  = int'(1) << f3[1:0];
    a     = int'(addr[2:0]);
    err   = (f3 == 3'b111) || (is_st && f3[2]);
`ifdef RISCV_LSU_MISALIGN_TRAP_EN
    if ((a % size) != 0) err = 1'b1;
`endif
    al = a - (a % size);
    be = 8'd0; wd = 64'd0; rd = 64'd0;
    for (int j = 0; j < size; j++) begin
      be[al+j]        = 1'b1;
      wd[8*(al+j)+:8] = wdata[8*j+:8];
      rd[8*j+:8]      = mem[8*(al+j)+:8];
    end
    if (!f3[2] && size < 8 && rd[8*size-1])
      for (int j = size; j < 8; j++) rd[8*j+:8] = 8'hFF;
    if (is_st || err) rd = 64'd0;
  endfunction

  // Driver: one complete access with a given number of memory wait cycles
  task automatic op(input bit ld, input bit st, input logic [2:0] f3,
                    input logic [63:0] addr, input logic [63:0] wdata,
                    input logic [63:0] mem, input int waits, input string tag);
    bit e;
    logic [7:0] be;
    logic [63:0] wd, rd;
    model(ld, st, f3, addr, wdata, mem, e, be, wd, rd);
    exp_q.push_back(rd);
    @(negedge clk);
    i_load = ld; i_store = st; i_f3 = f3; i_addr = addr; i_wdata = wdata;
    #1 check1({tag, "_stall_issue"}, o_stall, 1'b1);
    @(negedge clk);
    i_load = 1'b0; i_store = 1'b0;
    if (e) begin
      check1({tag, "_err_req"},   o_req,   1'b0);
      check1({tag, "_err_err"},   o_err,   1'b1);
      check1({tag, "_err_done"},  o_done,  1'b1);
      check1({tag, "_err_stall"}, o_stall, 1'b0);
      check({tag, "_err_rdata"},  o_rdata, exp_q.pop_front());
    end else begin
      for (int w = 0; w <= waits; w++) begin
        check1({tag, "_req"},   o_req,   1'b1);
        check1({tag, "_stall"}, o_stall, 1'b1);
        check1({tag, "_done0"}, o_done,  1'b0);
        check1({tag, "_we"},    o_we,    st && !ld);
        check({tag, "_addr"},   o_addr,  {addr[63:3], 3'b000});
        check({tag, "_be"},     64'(o_be), 64'(be));
        if (st && !ld) check({tag, "_wdata"}, o_wdata, wd);
        if (w == waits) begin
          i_ack = 1'b1; i_rdata = mem;
        end
        @(negedge clk);
      end
      i_ack = 1'b0; i_rdata = {$urandom, $urandom};
      check1({tag, "_done"},  o_done,  1'b1);
      check1({tag, "_err0"},  o_err,   1'b0);
      check1({tag, "_stall0"}, o_stall, 1'b0);
      check1({tag, "_req0"},  o_req,   1'b0);
      check({tag, "_rdata"},  o_rdata, exp_q.pop_front());
    end
    @(negedge clk);
    check1({tag, "_done_pulse"}, o_done, 1'b0);
  endtask

  initial begin
    i_load = 0; i_store = 0; i_ack = 0; i_f3 = 0;
    i_addr = 0; i_wdata = 0; i_rdata = 0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check1("rst_req",   o_req,   1'b0);
    check1("rst_we",    o_we,    1'b0);
    check1("rst_stall", o_stall, 1'b0);
    check1("rst_done",  o_done,  1'b0);
    check1("rst_err",   o_err,   1'b0);
    check("rst_addr",   o_addr,  64'd0);
    check("rst_be",     64'(o_be), 64'd0);
    check("rst_wdata",  o_wdata, 64'd0);
    check("rst_rdata",  o_rdata, 64'd0);
    rst = 1'b0;

    // directed examples
    op(0, 1, 3'b011, 64'h1008, 64'h1122334455667788, 64'h0, 0, "sd");
    op(0, 1, 3'b000, 64'h1003, 64'hAB, 64'h0, 1, "sb");
    op(1, 0, 3'b000, 64'h2005, 64'h0, 64'h0000_8000_0000_0000, 0, "lb");
    op(1, 0, 3'b100, 64'h2005, 64'h0, 64'h0000_8000_0000_0000, 2, "lbu");
    op(1, 0, 3'b010, 64'h2004, 64'h0, 64'h8000_0001_0000_0000, 0, "lw");
    op(1, 0, 3'b110, 64'h2004, 64'h0, 64'h8000_0001_0000_0000, 3, "lwu");
    op(1, 0, 3'b001, 64'h3001, 64'h0, 64'hFFEE_DDCC_BBAA_9988, 0, "lh_mis");
    op(0, 1, 3'b010, 64'h3006, 64'hDEADBEEF_CAFEF00D, 64'h0, 0, "sw_mis");
    op(1, 0, 3'b101, 64'h300E, 64'h0, 64'h8123_4567_89AB_CDEF, 1, "lhu");
    op(1, 0, 3'b011, 64'h4000, 64'h0, 64'h8123_4567_89AB_CDEF, 0, "ld");
    op(1, 1, 3'b010, 64'h5000, 64'h55, 64'hFFFF_FFFF_7FFF_FFFF, 0, "ld_st_both");
    op(1, 0, 3'b111, 64'h6000, 64'h0, 64'h1, 0, "ill_f3");
    op(0, 1, 3'b100, 64'h6000, 64'h12, 64'h0, 0, "ill_st");

    // randomized accesses
    for (int k = 0; k < 60; k++) begin
      int kind;
      kind = $urandom_range(0, 5);
      op(kind < 3, kind >= 3 && kind < 5 || kind == 5, 3'($urandom_range(0, 7)),
         {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
         $urandom_range(0, 3), "rnd");
    end

    // timeout: no ack ever
    @(negedge clk);
    i_load = 1'b1; i_f3 = 3'b011; i_addr = 64'h7000;
    @(negedge clk);
    i_load = 1'b0;
    for (int c = 0; c < TO; c++) begin
      check1("to_req", o_req, 1'b1);
      check1("to_err0", o_err, 1'b0);
      @(negedge clk);
    end
    check1("to_err",   o_err,  1'b1);
    check1("to_done",  o_done, 1'b1);
    check1("to_req0",  o_req,  1'b0);
    check("to_rdata",  o_rdata, 64'd0);
    @(negedge clk);
    check1("to_err_pulse", o_err, 1'b0);

    // reset during an outstanding request, then a late ack
    i_load = 1'b1; i_f3 = 3'b010; i_addr = 64'h8000;
    @(negedge clk);
    i_load = 1'b0;
    check1("mid_req", o_req, 1'b1);
    rst = 1'b1;
    #1;
    check1("mid_rst_req",   o_req,   1'b0);
    check1("mid_rst_stall", o_stall, 1'b0);
    check1("mid_rst_done",  o_done,  1'b0);
    @(negedge clk);
    rst = 1'b0;
    i_ack = 1'b1; i_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    i_ack = 1'b0;
    check1("late_ack_done", o_done, 1'b0);
    check1("late_ack_req",  o_req,  1'b0);
    check1("late_ack_err",  o_err,  1'b0);
    op(1, 0, 3'b000, 64'h8007, 64'h0, 64'h7F00_0000_0000_0000, 0, "post_rst");

    check("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
